knn_sorter_k: RTL and testbench

- Streaming K-nearest-neighbour insertion sorter; successor to the fixed 4-entry sorter.
- One query point (x,y) is loaded per run; candidate points stream in over a valid/ready handshake.
- The block keeps the K smallest squared Euclidean distances and their indices in ascending order.
- Sits between the KNN register file/data DMA and the CPU readout path.

---
 rtl/knn_sorter_k.sv | 232 +++++++++++++++++++++++
 tb/tb_knn_sorter_k.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/knn_sorter_k.sv
// knn_sorter_k: streaming K-nearest-neighbour insertion sorter on squared Euclidean distance.
// Define KNN_SORTER_VOTE_EN to store labels and add a majority vote over the kept neighbours.
module knn_sorter_k #(
    parameter int  COORD_W = 16,
    parameter int  K       = 4,
    parameter int  IDX_W   = 8,
    parameter int  LBL_W   = 4,
    localparam int SW      = (K > 1) ? $clog2(K) : 1,
    localparam int DW      = 2 * COORD_W + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] query_x,
    input  logic signed [COORD_W-1:0] query_y,
    input  logic                      pt_valid,
    output logic                      pt_ready,
    input  logic                      pt_last,
    input  logic signed [COORD_W-1:0] pt_x,
    input  logic signed [COORD_W-1:0] pt_y,
    input  logic [LBL_W-1:0]          pt_label,
    input  logic [SW-1:0]             sel,
    output logic [IDX_W-1:0]          idx_out,
    output logic [DW-1:0]             dist_out,
    output logic                      slot_valid,
    output logic                      busy,
    output logic                      done,
`ifdef KNN_SORTER_VOTE_EN
    output logic [LBL_W-1:0]          vote_label,
    output logic                      vote_valid,
`endif
    output logic                      ovf
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    state_e state_q, state_d;
    logic fl_q, fl_d, acc;
    logic [COORD_W-1:0] qx_q, qy_q;
    logic [IDX_W-1:0] cnt_q;
    logic ovf_q;
    logic st_vld_q;
    logic [DW-1:0] st_dist_q;
    logic [IDX_W-1:0] st_idx_q;
    logic vld_q [K];
    logic vld_d [K];
    logic [DW-1:0] dist_q [K];
    logic [DW-1:0] dist_d [K];
    logic [IDX_W-1:0] idx_q [K];
    logic [IDX_W-1:0] idx_d [K];
    logic [2*COORD_W+1:0] dxe, dye;
    logic [DW-1:0] dist_c;
    logic [SW-1:0] rs;
`ifdef KNN_SORTER_VOTE_EN
    logic [LBL_W-1:0] st_lbl_q;
    logic [LBL_W-1:0] lbl_q [K];
    logic [LBL_W-1:0] lbl_d [K];
`else
    logic unused_lbl;
    assign unused_lbl = ^pt_label;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            fl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fl_q    <= fl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fl_d    = 1'b0;
        if (start)
            state_d = RUN;
        else if (state_q == RUN && acc && pt_last)
            state_d = FLUSH;
        else if (state_q == FLUSH) begin
            fl_d    = !fl_q;
            state_d = fl_q ? DONE : FLUSH;
        end
    end

    always_comb begin
        pt_ready = state_q == RUN;
        busy     = state_q == RUN || state_q == FLUSH;
        done     = state_q == DONE;
    end

    assign acc = pt_valid && pt_ready;
    // Differences are formed at full product width so the unsigned square is exact.
    assign dxe = {{(COORD_W+2){pt_x[COORD_W-1]}}, pt_x} - {{(COORD_W+2){qx_q[COORD_W-1]}}, qx_q};
    assign dye = {{(COORD_W+2){pt_y[COORD_W-1]}}, pt_y} - {{(COORD_W+2){qy_q[COORD_W-1]}}, qy_q};
    assign dist_c = DW'(dxe * dxe + dye * dye);

    // Walk up the sorted list; once the entry lands, every higher slot takes its lower neighbour.
    always_comb begin
        logic prev, tk, c_vld;
        logic [DW-1:0] c_dist;
        logic [IDX_W-1:0] c_idx;
`ifdef KNN_SORTER_VOTE_EN
        logic [LBL_W-1:0] c_lbl;
        c_lbl = '0;
`endif
        prev   = 1'b0;
        c_vld  = 1'b0;
        c_dist = '0;
        c_idx  = '0;
        for (int i = 0; i < K; i++) begin
            tk        = st_vld_q && (!vld_q[i] || st_dist_q < dist_q[i]);
            vld_d[i]  = prev ? c_vld  : (tk ? 1'b1      : vld_q[i]);
            dist_d[i] = prev ? c_dist : (tk ? st_dist_q : dist_q[i]);
            idx_d[i]  = prev ? c_idx  : (tk ? st_idx_q  : idx_q[i]);
`ifdef KNN_SORTER_VOTE_EN
            lbl_d[i]  = prev ? c_lbl  : (tk ? st_lbl_q  : lbl_q[i]);
            c_lbl     = lbl_q[i];
`endif
            c_vld     = vld_q[i];
            c_dist    = dist_q[i];
            c_idx     = idx_q[i];
            prev      = prev | tk;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || start) begin
            if (!rst) begin
                qx_q <= '0;
                qy_q <= '0;
            end else begin
                qx_q <= query_x;
                qy_q <= query_y;
            end
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            st_vld_q  <= 1'b0;
            st_dist_q <= '0;
            st_idx_q  <= '0;
            for (int i = 0; i < K; i++) begin
                vld_q[i]  <= 1'b0;
                dist_q[i] <= '1;
                idx_q[i]  <= '0;
`ifdef KNN_SORTER_VOTE_EN
                lbl_q[i]  <= '0;
`endif
            end
`ifdef KNN_SORTER_VOTE_EN
            st_lbl_q <= '0;
`endif
        end else begin
            st_vld_q <= acc && !ovf_q;
            if (acc && !ovf_q) begin
                st_dist_q <= dist_c;
                st_idx_q  <= cnt_q;
                cnt_q     <= &cnt_q ? cnt_q : cnt_q + 1'b1;
                ovf_q     <= &cnt_q;
`ifdef KNN_SORTER_VOTE_EN
                st_lbl_q  <= pt_label;
`endif
            end
            vld_q  <= vld_d;
            dist_q <= dist_d;
            idx_q  <= idx_d;
`ifdef KNN_SORTER_VOTE_EN
            lbl_q  <= lbl_d;
`endif
        end
    end

    assign ovf        = ovf_q;
    assign rs         = (int'(sel) >= K) ? SW'(K - 1) : sel;
    assign slot_valid = vld_q[rs];
    assign idx_out    = idx_q[rs];
    assign dist_out   = dist_q[rs];

`ifdef KNN_SORTER_VOTE_EN
    localparam int NL = 2 ** LBL_W;
    localparam int CNT_W = $clog2(K + 1);

    logic vact_q, vv_q;
    logic [SW-1:0] vs_q;
    logic [LBL_W-1:0] vl_q, best_l;
    logic [CNT_W-1:0] cnt_l_q [NL];
    logic [CNT_W-1:0] cn [NL];
    logic [CNT_W-1:0] best_c;
    logic enter_done;

    assign enter_done = state_q == FLUSH && fl_q && !start;

    // Counts include the slot scanned this cycle; ties keep the label seen at the lowest slot.
    always_comb begin
        cn = cnt_l_q;
        cn[lbl_q[vs_q]] = vld_q[vs_q] ? cn[lbl_q[vs_q]] + 1'b1 : cn[lbl_q[vs_q]];
        best_c = '0;
        best_l = '0;
        for (int i = 0; i < K; i++) begin
            if (vld_q[i] && cn[lbl_q[i]] > best_c) begin
                best_c = cn[lbl_q[i]];
                best_l = lbl_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || start) begin
            vact_q <= 1'b0;
            vv_q   <= 1'b0;
            vl_q   <= '0;
            vs_q   <= '0;
            for (int i = 0; i < NL; i++)
                cnt_l_q[i] <= '0;
        end else if (enter_done) begin
            vact_q <= 1'b1;
            vs_q   <= '0;
            for (int i = 0; i < NL; i++)
                cnt_l_q[i] <= '0;
        end else if (vact_q) begin
            cnt_l_q <= cn;
            vs_q    <= vs_q + 1'b1;
            if (vs_q == SW'(K - 1)) begin
                vact_q <= 1'b0;
                vv_q   <= 1'b1;
                vl_q   <= best_l;
            end
        end
    end

    assign vote_label = vl_q;
    assign vote_valid = vv_q;
`endif
endmodule

// File: tb/tb_knn_sorter_k.sv
// tb_knn_sorter_k: scoreboard bench for knn_sorter_k; expected lists are queued at the last beat
// and compared by a monitor when done rises.
module tb_knn_sorter_k;
    localparam int CW = 16, K = 4, IW = 8, LW = 4, SW = 2, DW = 2 * CW + 1;

    logic clk = 0, rst = 0, start = 0, pt_valid = 0, pt_last = 0;
    logic [CW-1:0] query_x = 0, query_y = 0, pt_x = 0, pt_y = 0;
    logic [LW-1:0] pt_label = 0;
    logic [SW-1:0] sel = 0;
    logic pt_ready, slot_valid, busy, done, ovf;
    logic [IW-1:0] idx_out;
    logic [DW-1:0] dist_out;
`ifdef KNN_SORTER_VOTE_EN
    logic [LW-1:0] vote_label;
    logic vote_valid;
`endif
    int checks = 0, fails = 0;

    typedef struct packed {logic v; logic [IW-1:0] ix; logic [DW-1:0] d;} slot_t;
    typedef struct packed {slot_t [K-1:0] s; logic ovf; logic [63:0] t; logic [31:0] vote;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    knn_sorter_k #(.COORD_W(CW), .K(K), .IDX_W(IW), .LBL_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .query_x(query_x), .query_y(query_y),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_last(pt_last), .pt_x(pt_x), .pt_y(pt_y),
        .pt_label(pt_label), .sel(sel), .idx_out(idx_out), .dist_out(dist_out),
        .slot_valid(slot_valid), .busy(busy), .done(done),
`ifdef KNN_SORTER_VOTE_EN
        .vote_label(vote_label), .vote_valid(vote_valid),
`endif
        .ovf(ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic slot_t sl(input logic v, input logic [IW-1:0] ix, input logic [DW-1:0] d);
        return {v, ix, d};
    endfunction

    function automatic slot_t inv();
        return sl(1'b0, '0, {DW{1'b1}});
    endfunction

    task automatic expect_run(input slot_t s0, s1, s2, s3, input logic ov, input time ta,
                              input int vote);
        exp_t e;
        e.s[0] = s0; e.s[1] = s1; e.s[2] = s2; e.s[3] = s3;
        e.ovf = ov;
        e.t = ta + 20;
        e.vote = vote;
        q.push_back(e);
    endtask

    task automatic do_start(input logic [CW-1:0] x, y);
        @(negedge clk);
        start = 1; query_x = x; query_y = y;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send(input logic [CW-1:0] x, y, input logic [LW-1:0] lb, input logic last,
                        output time ta);
        int n;
        n = 0;
        @(negedge clk);
        pt_x = x; pt_y = y; pt_label = lb; pt_last = last; pt_valid = 1;
        while (!pt_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pt_ready", pt_ready, 1);
        @(posedge clk);
        ta = $time;
        #1 pt_valid = 0; pt_last = 0;
    endtask

    // Monitor: owns sel, pops one expected list per rising done.
    initial begin
        logic done_p;
        exp_t e;
        int n;
        done_p = 0;
        forever begin
            @(negedge clk);
            if (done && !done_p) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("done_time", $time - 5, e.t);
                    for (int s = 0; s < K; s++) begin
                        sel = SW'(s);
                        #1;
                        chk("slot_valid", slot_valid, e.s[s].v);
                        chk("idx_out", idx_out, e.s[s].ix);
                        chk("dist_out", dist_out, e.s[s].d);
                    end
                    sel = 0;
                    chk("ovf", ovf, e.ovf);
`ifdef KNN_SORTER_VOTE_EN
                    if ($signed(e.vote) >= 0) begin
                        n = 0;
                        while (!vote_valid && n < 3 * K) begin
                            @(negedge clk);
                            n++;
                        end
                        chk("vote_time", $time - 5, e.t + K * 10);
                        chk("vote_label", vote_label, e.vote);
                    end
`endif
                end
            end
            done_p = done;
        end
    end

    initial begin
        time ta;
        #12;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", pt_ready, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_slot_valid", slot_valid, 0);
        chk("rst_dist", dist_out, {DW{1'b1}});
        chk("rst_idx", idx_out, 0);
        @(negedge clk) rst = 1;

        // Mixed distances with a tie at 25 that must be discarded.
        do_start(0, 0);
        send(3, 4, 0, 0, ta);
        send(1, 1, 0, 0, ta);
        send(0, 2, 0, 0, ta);
        send(5, 0, 0, 0, ta);
        send(1, 0, 0, 1, ta);
        expect_run(sl(1, 4, 1), sl(1, 1, 2), sl(1, 2, 4), sl(1, 0, 25), 0, ta, -1);
        repeat (12) @(negedge clk);

        // Extreme corners: no truncation of the 33-bit distance.
        do_start(16'h8000, 16'h8000);
        send(16'h7fff, 16'h7fff, 0, 1, ta);
        expect_run(sl(1, 0, 33'd8589672450), inv(), inv(), inv(), 0, ta, -1);
        repeat (12) @(negedge clk);

        // Equal distances keep arrival order.
        do_start(0, 0);
        send(3, 0, 0, 0, ta);
        send(0, 3, 0, 0, ta);
        send(0, 16'hfffd, 0, 1, ta);
        expect_run(sl(1, 0, 9), sl(1, 1, 9), sl(1, 2, 9), inv(), 0, ta, -1);
        repeat (12) @(negedge clk);

        // Counter saturation: beats 256 and 257 are closer but must not be inserted.
        do_start(0, 0);
        for (int i = 0; i < 258; i++) send(16'(300 - i), 0, 0, i == 257, ta);
        expect_run(sl(1, 255, 2025), sl(1, 254, 2116), sl(1, 253, 2209), sl(1, 252, 2304), 1,
                   ta, -1);
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of a stream.
        do_start(0, 0);
        @(negedge clk);
        pt_x = 7; pt_y = 0; pt_valid = 1;
        repeat (3) @(negedge clk);
        chk("run_busy", busy, 1);
        chk("run_slot0_valid", slot_valid, 1);
        #2 rst = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", pt_ready, 0);
        chk("arst_done", done, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_slot_valid", slot_valid, 0);
        chk("arst_dist", dist_out, {DW{1'b1}});
        chk("arst_idx", idx_out, 0);
        pt_valid = 0;
        @(negedge clk) rst = 1;
        repeat (2) @(negedge clk);
        chk("post_rst_slot_valid", slot_valid, 0);
        do_start(1, 1);
        send(2, 16'hffff, 0, 1, ta);
        expect_run(sl(1, 0, 5), inv(), inv(), inv(), 0, ta, -1);
        repeat (12) @(negedge clk);

`ifdef KNN_SORTER_VOTE_EN
        // Labels 2,5,2,5 tie at two votes each; the label at slot 0 wins.
        do_start(0, 0);
        send(1, 0, 2, 0, ta);
        send(2, 0, 5, 0, ta);
        send(3, 0, 2, 0, ta);
        send(4, 0, 5, 0, ta);
        send(5, 0, 7, 1, ta);
        expect_run(sl(1, 0, 1), sl(1, 1, 4), sl(1, 2, 9), sl(1, 3, 16), 0, ta, 2);
        repeat (16) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        chk("pending_expectations", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
